// File: rtl/rainbow_pwm_led.sv
// Rainbow hue-wheel walker driving a 3-pin RGB LED with per-channel PWM.
// Duty registers reload only at PWM period boundaries, so the LED waveform stays glitch-free.
module rainbow_pwm_led #(
   parameter int CLK_HZ     = 12_000_000,
   parameter int CYCLE_MS   = 10_000,
   parameter int PWM_BITS   = 5,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pause,
   input  logic                dir,
   input  logic [PWM_BITS:0]   brightness,
   output logic [2:0]          led,
   output logic [2:0]          hue_seg,
   output logic [PWM_BITS-1:0] hue_frac,
   output logic                wrap
);

   localparam int FULL       = 1 << PWM_BITS;
   localparam int STEP_TICKS = (CLK_HZ / 1000 * CYCLE_MS) / (6 * FULL);
   localparam int TW         = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam int LW         = PWM_BITS + 1;

   localparam logic [TW-1:0]       TICK_MAX = TW'(STEP_TICKS - 1);
   localparam logic [PWM_BITS-1:0] FRAC_MAX = {PWM_BITS{1'b1}};
   localparam logic [LW-1:0]       FULL_L   = LW'(FULL);
   localparam logic [2:0]          LED_OFF  = {3{ACTIVE_LOW}};

   generate
      if (STEP_TICKS < 1) begin : g_bad_step
         $error("rainbow_pwm_led: STEP_TICKS < 1, clock too slow for CYCLE_MS");
      end
   endgenerate

   logic [TW-1:0]       tick_q, tick_d;
   logic [2:0]          seg_q, seg_d;
   logic [PWM_BITS-1:0] frac_q, frac_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [LW-1:0]       duty_r_q, duty_g_q, duty_b_q;
   logic [LW-1:0]       duty_r_d, duty_g_d, duty_b_d;
   logic                wrap_q, wrap_d;
   logic [2:0]          led_q, led_d;
   logic [LW-1:0]       lvl_r, lvl_g, lvl_b, bri, frac_e, frac_inv;
   logic                step;
   logic [2:0]          lit;

   function automatic logic [LW-1:0] scale(input logic [LW-1:0] l, input logic [LW-1:0] b);
      logic [2*LW-1:0] p;
      p = {{LW{1'b0}}, l} * {{LW{1'b0}}, b};
      return p[PWM_BITS +: LW];
   endfunction

   assign step = !pause && (tick_q == TICK_MAX);

   always_comb begin
      tick_d = tick_q;
      seg_d  = seg_q;
      frac_d = frac_q;
      wrap_d = 1'b0;
      if (!pause) begin
         tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
      end
      if (step) begin
         if (!dir) begin
            if (frac_q == FRAC_MAX) begin
               frac_d = '0;
               if (seg_q == 3'd5) begin
                  seg_d  = 3'd0;
                  wrap_d = 1'b1;
               end else begin
                  seg_d = seg_q + 3'd1;
               end
            end else begin
               frac_d = frac_q + 1'b1;
            end
         end else begin
            if (frac_q == '0) begin
               frac_d = FRAC_MAX;
               if (seg_q == 3'd0) begin
                  seg_d  = 3'd5;
                  wrap_d = 1'b1;
               end else begin
                  seg_d = seg_q - 3'd1;
               end
            end else begin
               frac_d = frac_q - 1'b1;
            end
         end
      end
   end

   // Hue wheel: each segment ramps exactly one channel up or down.
   always_comb begin
      frac_e   = {1'b0, frac_q};
      frac_inv = FULL_L - frac_e;
      lvl_r    = '0;
      lvl_g    = '0;
      lvl_b    = '0;
      case (seg_q)
         3'd0: begin lvl_r = FULL_L;   lvl_g = frac_e;   end
         3'd1: begin lvl_r = frac_inv; lvl_g = FULL_L;   end
         3'd2: begin lvl_g = FULL_L;   lvl_b = frac_e;   end
         3'd3: begin lvl_g = frac_inv; lvl_b = FULL_L;   end
         3'd4: begin lvl_r = frac_e;   lvl_b = FULL_L;   end
         3'd5: begin lvl_r = FULL_L;   lvl_b = frac_inv; end
         default: ;
      endcase
   end

   assign bri = (brightness > FULL_L) ? FULL_L : brightness;

   always_comb begin
      pwm_d    = pwm_q + 1'b1;
      duty_r_d = duty_r_q;
      duty_g_d = duty_g_q;
      duty_b_d = duty_b_q;
      if (pwm_q == FRAC_MAX) begin
         duty_r_d = scale(lvl_r, bri);
         duty_g_d = scale(lvl_g, bri);
         duty_b_d = scale(lvl_b, bri);
      end
      lit   = {({1'b0, pwm_q} < duty_r_q), ({1'b0, pwm_q} < duty_b_q), ({1'b0, pwm_q} < duty_g_q)};
      led_d = lit ^ LED_OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q   <= '0;
         seg_q    <= '0;
         frac_q   <= '0;
         pwm_q    <= '0;
         duty_r_q <= '0;
         duty_g_q <= '0;
         duty_b_q <= '0;
         wrap_q   <= 1'b0;
         led_q    <= LED_OFF;
      end else begin
         tick_q   <= tick_d;
         seg_q    <= seg_d;
         frac_q   <= frac_d;
         pwm_q    <= pwm_d;
         duty_r_q <= duty_r_d;
         duty_g_q <= duty_g_d;
         duty_b_q <= duty_b_d;
         wrap_q   <= wrap_d;
         led_q    <= led_d;
      end
   end

   assign led      = led_q;
   assign hue_seg  = seg_q;
   assign hue_frac = frac_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_rainbow_pwm_led.sv
// Bench for rainbow_pwm_led: hue position tracked as a single integer on a 6*FULL wheel.
module tb_rainbow_pwm_led;
   localparam int F    = 32;
   localparam int STEP = 32;
   localparam int NPOS = 6 * F;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pause = 1'b0;
   logic       dir = 1'b0;
   logic [5:0] brightness = 6'd32;
   logic [2:0] led;
   logic [2:0] hue_seg;
   logic [4:0] hue_frac;
   logic       wrap;

   always #5 clk = ~clk;

   rainbow_pwm_led #(
      .CLK_HZ(64_000), .CYCLE_MS(96), .PWM_BITS(5), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .pause(pause), .dir(dir), .brightness(brightness),
      .led(led), .hue_seg(hue_seg), .hue_frac(hue_frac), .wrap(wrap)
   );

   int total = 0;
   int bad   = 0;
   int m_tick, m_pos, m_pwm, m_wrap, since;
   int m_duty [3];
   logic [2:0] m_led;
   int wraps[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Channel level 0=R 1=G 2=B for a wheel position.
   function automatic int lvl(input int c, input int pos);
      int s, f, r, g, b;
      s = pos / F;
      f = pos % F;
      r = 0; g = 0; b = 0;
      case (s)
         0: begin r = F;     g = f;     end
         1: begin r = F - f; g = F;     end
         2: begin g = F;     b = f;     end
         3: begin g = F - f; b = F;     end
         4: begin r = f;     b = F;     end
         default: begin r = F; b = F - f; end
      endcase
      return (c == 0) ? r : ((c == 1) ? g : b);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_tick = 0; m_pos = 0; m_pwm = 0; m_wrap = 0; since = 0;
         m_duty = '{0, 0, 0};
         m_led = 3'b111;
      end else begin
         int br;
         br = (brightness > F) ? F : int'(brightness);
         m_led = {!(m_pwm < m_duty[0]), !(m_pwm < m_duty[2]), !(m_pwm < m_duty[1])};
         if (m_pwm == F - 1)
            for (int c = 0; c < 3; c++) m_duty[c] = lvl(c, m_pos) * br / F;
         m_pwm = (m_pwm + 1) % F;
         m_wrap = 0;
         if (!pause) begin
            m_tick++;
            if (m_tick == STEP) begin
               m_tick = 0;
               if (!dir) begin
                  m_wrap = (m_pos == NPOS - 1);
                  m_pos  = (m_pos + 1) % NPOS;
               end else begin
                  m_wrap = (m_pos == 0);
                  m_pos  = (m_pos + NPOS - 1) % NPOS;
               end
            end
         end
         since++;
      end
   end

   always @(posedge clk) begin
      #1;
      chk("led",  led,      m_led);
      chk("seg",  hue_seg,  m_pos / F);
      chk("frac", hue_frac, m_pos % F);
      chk("wrap", wrap,     m_wrap);
      if (wrap === 1'b1) wraps.push_back(since);
   end

   task automatic step_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      step_n(n);
      rst = 1'b0;
   endtask

   task automatic count_period(output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      repeat (F) begin
         @(negedge clk);
         r += int'(led[2] === 1'b0);
         b += int'(led[1] === 1'b0);
         g += int'(led[0] === 1'b0);
      end
   endtask

   initial begin
      int r, g, b, s0, f0, nw;

      @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("rst_led", led, 3'b111);
         chk("rst_seg", hue_seg, 0);
         chk("rst_frac", hue_frac, 0);
         chk("rst_wrap", wrap, 0);
      end
      rst = 1'b0;
      step_n(32); chk("led_e32", led, 3'b111);
      step_n(1);  chk("led_e33", led, 3'b011);
      step_n(31); chk("led_e64", led, 3'b011);
      step_n(1);  chk("led_e65", led, 3'b010);

      step_n(544 - 65);
      chk("frac_e544", hue_frac, 17);
      count_period(r, g, b);
      chk("mid_red", r, 32);
      chk("mid_green", g, 16);
      chk("mid_blue", b, 0);

      step_n(12300 - 576);
      chk("wrap_count", wraps.size(), 2);
      chk("wrap0_at", (wraps.size() > 0) ? wraps[0] : -1, 6144);
      chk("wrap1_at", (wraps.size() > 1) ? wraps[1] : -1, 12288);

      dir = 1'b1;
      do_reset(2);
      step_n(31);
      chk("rev_seg_e31", hue_seg, 0);
      chk("rev_wrap_e31", wrap, 0);
      step_n(1);
      chk("rev_seg_e32", hue_seg, 5);
      chk("rev_frac_e32", hue_frac, 31);
      chk("rev_wrap_e32", wrap, 1);
      step_n(1);
      chk("rev_wrap_e33", wrap, 0);
      step_n(64 - 33);
      count_period(r, g, b);
      chk("rev_red", r, 32);
      chk("rev_blue", b, 1);
      chk("rev_green", g, 0);

      dir = 1'b0;
      step_n(2000);
      pause = 1'b1;
      s0 = hue_seg; f0 = hue_frac; nw = wraps.size();
      step_n(1000);
      chk("pause_seg", hue_seg, s0);
      chk("pause_frac", hue_frac, f0);
      chk("pause_nowrap", wraps.size(), nw);
      pause = 1'b0;
      step_n(200);

      brightness = 6'd16;
      do_reset(2); step_n(32); count_period(r, g, b);
      chk("br16_red", r, 16);
      brightness = 6'd40;
      do_reset(2); step_n(32); count_period(r, g, b);
      chk("br40_red", r, 32);
      brightness = 6'd0;
      do_reset(2); step_n(32); count_period(r, g, b);
      chk("br0_all", r + g + b, 0);
      brightness = 6'd32;
      step_n(700);
      rst = 1'b1;
      step_n(1);
      chk("midrst_led", led, 3'b111);
      chk("midrst_seg", hue_seg, 0);
      chk("midrst_frac", hue_frac, 0);
      rst = 1'b0;

      repeat (300) begin
         pause      = ($urandom_range(0, 9) == 0);
         dir        = 1'($urandom_range(0, 1));
         brightness = 6'($urandom_range(0, 63));
         rst        = ($urandom_range(0, 49) == 0);
         step_n($urandom_range(1, 100));
      end
      rst = 1'b0;
      pause = 1'b0;
      step_n(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
